// File: rtl/mfda_outlet_collector.sv
// Outlet-side collection controller: primes the outlet to waste, then fills each
// collection chamber with a target number of detected units and reports it to the host.
module mfda_outlet_collector #(
    parameter int NUM_CHAMBERS  = 4,
    parameter int CNT_W         = 8,
    parameter int PRIME_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int TMO_W         = 16,
    parameter int IDX_W         = (NUM_CHAMBERS > 1) ? $clog2(NUM_CHAMBERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        target,
    input  logic [TMO_W-1:0]        tmo_limit,
    input  logic                    det_in,
    output logic                    valve_waste,
    output logic [NUM_CHAMBERS-1:0] valve_collect,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [IDX_W-1:0]        rec_idx,
    output logic [CNT_W-1:0]        rec_count,
    output logic                    rec_tmo
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRIME   = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_REPORT  = 2'd3;

    localparam int PH_W = $clog2(PRIME_CYCLES + SETTLE_CYCLES + 1);
    localparam logic [PH_W-1:0]  PRIME_LAST  = PH_W'(PRIME_CYCLES - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CHAMBERS - 1);

    logic [1:0]              r_state;
    logic                    r_det_s1, r_det_s2, r_det_prev, r_det_pulse;
    logic [PH_W-1:0]         r_phase_cnt;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic [CNT_W-1:0]        r_target;
    logic [TMO_W-1:0]        r_tmo_limit;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_count;
    logic                    r_rec_tmo;
    logic                    r_rec_valid;
    logic                    r_acked;
    logic                    r_valve_waste;
    logic [NUM_CHAMBERS-1:0] r_valve_collect;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    logic [1:0]              w_state_next;
    logic [PH_W-1:0]         w_phase_next;
    logic [TMO_W-1:0]        w_tmo_next;
    logic [CNT_W-1:0]        w_target_next;
    logic [TMO_W-1:0]        w_limit_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic [CNT_W-1:0]        w_count_next;
    logic [CNT_W-1:0]        w_count_inc;
    logic                    w_rec_tmo_next;
    logic                    w_rec_valid_next;
    logic                    w_acked_next;
    logic                    w_done_next;
    logic                    w_error_next;
    logic                    w_timeout;
    logic                    w_handshake;
    logic [NUM_CHAMBERS-1:0] w_onehot;

    // Two-flop synchronizer plus registered rising-edge detect on the raw detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det_s1    <= 1'b0;
            r_det_s2    <= 1'b0;
            r_det_prev  <= 1'b0;
            r_det_pulse <= 1'b0;
        end else begin
            r_det_s1    <= det_in;
            r_det_s2    <= r_det_s1;
            r_det_prev  <= r_det_s2;
            r_det_pulse <= r_det_s2 & ~r_det_prev;
        end
    end

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_timeout   = (r_tmo_limit != '0) && (r_tmo_cnt == r_tmo_limit);
    assign w_handshake = r_rec_valid && rec_ready;

    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase_cnt;
        w_tmo_next       = r_tmo_cnt;
        w_target_next    = r_target;
        w_limit_next     = r_tmo_limit;
        w_idx_next       = r_idx;
        w_count_next     = r_count;
        w_rec_tmo_next   = r_rec_tmo;
        w_rec_valid_next = 1'b0;
        w_acked_next     = r_acked;
        w_done_next      = 1'b0;
        w_error_next     = r_error;
        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (target != '0)) begin
                        w_state_next   = S_PRIME;
                        w_target_next  = target;
                        w_limit_next   = tmo_limit;
                        w_idx_next     = '0;
                        w_count_next   = '0;
                        w_rec_tmo_next = 1'b0;
                        w_phase_next   = '0;
                        w_error_next   = 1'b0;
                    end
                end
                S_PRIME: begin
                    if (r_phase_cnt == PRIME_LAST) begin
                        w_state_next = S_COLLECT;
                        w_tmo_next   = '0;
                    end else begin
                        w_phase_next = r_phase_cnt + PH_W'(1);
                    end
                end
                S_COLLECT: begin
                    // A detection in the same cycle as the timeout takes precedence.
                    if (r_det_pulse) begin
                        w_count_next = w_count_inc;
                        w_tmo_next   = '0;
                        if (w_count_inc == r_target) begin
                            w_state_next     = S_REPORT;
                            w_rec_tmo_next   = 1'b0;
                            w_phase_next     = '0;
                            w_rec_valid_next = 1'b1;
                            w_acked_next     = 1'b0;
                        end
                    end else if (w_timeout) begin
                        w_state_next     = S_REPORT;
                        w_rec_tmo_next   = 1'b1;
                        w_error_next     = 1'b1;
                        w_phase_next     = '0;
                        w_rec_valid_next = 1'b1;
                        w_acked_next     = 1'b0;
                    end else if (r_tmo_cnt != '1) begin
                        w_tmo_next = r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_REPORT: begin
                    // The host may accept before settling ends; remember it and drop valid.
                    w_acked_next     = r_acked | w_handshake;
                    w_rec_valid_next = r_rec_valid & ~rec_ready;
                    if (r_phase_cnt != SETTLE_LAST) begin
                        w_phase_next = r_phase_cnt + PH_W'(1);
                    end
                    if (w_acked_next && (r_phase_cnt == SETTLE_LAST)) begin
                        if (r_rec_tmo || (r_idx == IDX_LAST)) begin
                            w_state_next = S_IDLE;
                            w_done_next  = ~r_rec_tmo;
                        end else begin
                            w_state_next = S_COLLECT;
                            w_idx_next   = r_idx + IDX_W'(1);
                            w_count_next = '0;
                            w_tmo_next   = '0;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAMBERS; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_idx_next == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_phase_cnt     <= '0;
            r_tmo_cnt       <= '0;
            r_target        <= '0;
            r_tmo_limit     <= '0;
            r_idx           <= '0;
            r_count         <= '0;
            r_rec_tmo       <= 1'b0;
            r_rec_valid     <= 1'b0;
            r_acked         <= 1'b0;
            r_valve_waste   <= 1'b0;
            r_valve_collect <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_phase_cnt     <= w_phase_next;
            r_tmo_cnt       <= w_tmo_next;
            r_target        <= w_target_next;
            r_tmo_limit     <= w_limit_next;
            r_idx           <= w_idx_next;
            r_count         <= w_count_next;
            r_rec_tmo       <= w_rec_tmo_next;
            r_rec_valid     <= w_rec_valid_next;
            r_acked         <= w_acked_next;
            r_done          <= w_done_next;
            r_error         <= w_error_next;
            // Valves are registered from the next state so they never glitch.
            r_valve_waste   <= (w_state_next == S_PRIME) || (w_state_next == S_REPORT);
            r_valve_collect <= (w_state_next == S_COLLECT) ? w_onehot : '0;
            r_busy          <= (w_state_next != S_IDLE);
        end
    end

    assign valve_waste   = r_valve_waste;
    assign valve_collect = r_valve_collect;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign rec_valid     = r_rec_valid;
    assign rec_idx       = r_idx;
    assign rec_count     = r_count;
    assign rec_tmo       = r_rec_tmo;

endmodule

// File: tb/tb_mfda_outlet_collector.sv
// Scoreboard bench for the outlet collector: expected records are queued as each
// run is launched and matched against every accepted host record.
module tb_mfda_outlet_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  target = '0;
    logic [15:0] tmo_limit = '0;
    logic        det_in = 1'b0;
    logic        valve_waste;
    logic [3:0]  valve_collect;
    logic        busy;
    logic        done;
    logic        error;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [1:0]  rec_idx;
    logic [7:0]  rec_count;
    logic        rec_tmo;

    mfda_outlet_collector dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target(target), .tmo_limit(tmo_limit), .det_in(det_in),
        .valve_waste(valve_waste), .valve_collect(valve_collect),
        .busy(busy), .done(done), .error(error),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_idx(rec_idx), .rec_count(rec_count), .rec_tmo(rec_tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cnt;
        int tmo;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   extra_recs = 0;
    int   valve_viol = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes, done pulses and the valve invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (($countones(valve_collect) > 1) || (valve_waste && (valve_collect != '0)))
                valve_viol++;
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    extra_recs++;
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    $display("[TB] record idx=%0d count=%0d tmo=%0d", rec_idx, rec_count, rec_tmo);
                    check_value("rec_idx", 32'(rec_idx), 32'(e.idx));
                    check_value("rec_count", 32'(rec_count), 32'(e.cnt));
                    check_value("rec_tmo", 32'(rec_tmo), 32'(e.tmo));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_det(input int hi, input int total);
        det_in = 1'b1;
        repeat (hi) tick();
        det_in = 1'b0;
        repeat (total - hi) tick();
    endtask

    task automatic do_start(input logic [7:0] t, input logic [15:0] lim);
        target = t;
        tmo_limit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_rec(input int idx, input int cnt, input int tmo);
        rec_t r;
        r.idx = idx;
        r.cnt = cnt;
        r.tmo = tmo;
        exp_q.push_back(r);
    endtask

    // sel 0: rec_valid, 1: idle, 2: valve_collect == mask
    task automatic wait_until(input int sel, input logic [3:0] mask, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 && rec_valid) || (sel == 1 && !busy) || (sel == 2 && valve_collect == mask)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit ok;
        int n;
        int done_snap;

        repeat (3) tick();
        check_value("reset_outputs",
                    32'({valve_waste, valve_collect, busy, done, error, rec_valid, rec_idx, rec_count, rec_tmo}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal run
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_rec(i, 3, 0);
        do_start(8'd3, 16'd100);
        n = 0;
        while (valve_waste && n < 40) begin
            n++;
            tick();
        end
        check_value("prime_len", 32'(n), 32'd16);
        check_value("first_collect", 32'(valve_collect), 32'h1);
        for (int i = 0; i < 12; i++) pulse_det(2, 10);
        wait_until(1, 4'h0, 200, ok);
        check_value("nom_idle", 32'(ok), 32'd1);
        tick();
        check_value("nom_done", 32'(done_cnt), 32'd1);
        check_value("nom_error", 32'(error), 32'd0);
        check_value("nom_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure on the first record
        rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_rec(i, 3, 0);
        do_start(8'd3, 16'd100);
        repeat (16) tick();
        for (int i = 0; i < 3; i++) pulse_det(2, 10);
        wait_until(0, 4'h0, 50, ok);
        check_value("bp_valid_seen", 32'(ok), 32'd1);
        repeat (20) tick();
        check_value("bp_hold", 32'({rec_valid, rec_idx, rec_count, valve_waste}), 32'({1'b1, 2'd0, 8'd3, 1'b1}));
        rec_ready = 1'b1;
        tick();
        check_value("bp_next_collect", 32'({rec_valid, valve_collect}), 32'({1'b0, 4'h2}));
        for (int i = 0; i < 9; i++) pulse_det(2, 10);
        wait_until(1, 4'h0, 200, ok);
        tick();
        check_value("bp_done", 32'(done_cnt), 32'd2);

        // Timeout after two units
        push_rec(0, 2, 1);
        done_snap = done_cnt;
        do_start(8'd5, 16'd50);
        repeat (16) tick();
        for (int i = 0; i < 2; i++) pulse_det(2, 10);
        wait_until(1, 4'h0, 300, ok);
        tick();
        check_value("tmo_idle", 32'(ok), 32'd1);
        check_value("tmo_error", 32'(error), 32'd1);
        check_value("tmo_no_done", 32'(done_cnt), 32'(done_snap));
        check_value("tmo_valves", 32'({valve_waste, valve_collect}), 32'd0);

        // Edge detect: pulse in PRIME, long level in COLLECT, pulse in REPORT
        rec_ready = 1'b0;
        push_rec(0, 2, 0);
        push_rec(1, 2, 0);
        do_start(8'd2, 16'd0);
        check_value("start_clears_error", 32'(error), 32'd0);
        tick();
        pulse_det(2, 15);
        check_value("sync_in_collect", 32'(valve_collect), 32'h1);
        pulse_det(30, 40);
        check_value("sync_level_once", 32'({valve_waste, valve_collect}), 32'h1);
        pulse_det(2, 2);
        wait_until(0, 4'h0, 30, ok);
        check_value("sync_rec_valid", 32'(ok), 32'd1);
        pulse_det(2, 10);
        rec_ready = 1'b1;
        tick();
        check_value("sync_ch1", 32'(valve_collect), 32'h2);
        pulse_det(2, 10);
        check_value("sync_report_ignored", 32'({valve_waste, valve_collect}), 32'h2);
        pulse_det(2, 2);
        wait_until(2, 4'h4, 40, ok);
        check_value("sync_ch2", 32'(ok), 32'd1);

        // Abort in chamber 2
        done_snap = done_cnt;
        pulse_det(2, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_value("abort_outputs", 32'({valve_waste, valve_collect, busy, rec_valid}), 32'd0);
        tick();
        check_value("abort_no_done", 32'(done_cnt), 32'(done_snap));
        do_start(8'd0, 16'd10);
        tick();
        check_value("zero_target_ignored", 32'({busy, valve_waste, error}), 32'd0);

        // Async reset while a record is pending
        rec_ready = 1'b0;
        do_start(8'd1, 16'd0);
        repeat (16) tick();
        pulse_det(2, 2);
        wait_until(0, 4'h0, 30, ok);
        check_value("rst_pre_valid", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_reset_outputs",
                    32'({valve_waste, valve_collect, busy, done, error, rec_valid, rec_idx, rec_count, rec_tmo}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        done_snap = done_cnt;
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_rec(i, 1, 0);
        do_start(8'd1, 16'd0);
        repeat (16) tick();
        for (int i = 0; i < 4; i++) pulse_det(2, 10);
        wait_until(1, 4'h0, 100, ok);
        tick();
        check_value("restart_done", 32'(done_cnt), 32'(done_snap + 1));

        check_value("final_q_empty", 32'(exp_q.size()), 32'd0);
        check_value("extra_records", 32'(extra_recs), 32'd0);
        check_value("valve_invariant", 32'(valve_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
